// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test sequencer.
//   - RV32I opcode and funct3 encodings used to build the 11-bit
//     {funct7[5], funct3, opcode} field consumed by alu_controller.
//   - Op-table size, LFSR taps, FSM state type.
//   - op_fn(): maps an op-table index to the ALU function it exercises.
//   - op_is_shift(): true for op-table entries whose operand B is a shift amount.
package alu_bist_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int          BIST_OPS  = 26;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_PASS,
    ST_FAIL
  } bist_state_t;

  typedef enum logic [3:0] {
    FN_ADD,
    FN_SUB,
    FN_XOR,
    FN_OR,
    FN_AND,
    FN_SLL,
    FN_SRL,
    FN_SRA,
    FN_SLT,
    FN_SLTU
  } alu_fn_t;

  // Entries 19..25 (loads, stores, branches, jumps, LUI, AUIPC) all
  // reduce to an address-style add in the execute stage.
  function automatic alu_fn_t op_fn(input logic [4:0] idx);
    case (idx)
      5'd0, 5'd10:  return FN_ADD;
      5'd1:         return FN_SUB;
      5'd2, 5'd11:  return FN_XOR;
      5'd3, 5'd12:  return FN_OR;
      5'd4, 5'd13:  return FN_AND;
      5'd5, 5'd14:  return FN_SLL;
      5'd6, 5'd15:  return FN_SRL;
      5'd7, 5'd16:  return FN_SRA;
      5'd8, 5'd17:  return FN_SLT;
      5'd9, 5'd18:  return FN_SLTU;
      default:      return FN_ADD;
    endcase
  endfunction

  function automatic logic op_is_shift(input logic [4:0] idx);
    case (op_fn(idx))
      FN_SLL, FN_SRL, FN_SRA: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_bist_sequencer_golden.sv
// alu_golden_model: combinational reference result for one op-table entry.
// Ports:
//   op_idx_i    in  5       op-table index (0..25)
//   a_i         in  VWIDTH  operand A
//   b_i         in  VWIDTH  operand B (shift amount in its low bits for shifts)
//   expected_o  out VWIDTH  value a correct execute stage must produce
module alu_golden_model
  import alu_bist_pkg::*;
#(
  parameter int VWIDTH = 32
) (
  input  logic [4:0]        op_idx_i,
  input  logic [VWIDTH-1:0] a_i,
  input  logic [VWIDTH-1:0] b_i,
  output logic [VWIDTH-1:0] expected_o
);

  localparam int SHW = $clog2(VWIDTH);

  logic signed [VWIDTH-1:0] a_s;
  logic signed [VWIDTH-1:0] b_s;
  logic        [SHW-1:0]    shamt;

  assign a_s   = a_i;
  assign b_s   = b_i;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    expected_o = '0;
    case (op_fn(op_idx_i))
      FN_ADD:  expected_o = a_i + b_i;
      FN_SUB:  expected_o = a_i - b_i;
      FN_XOR:  expected_o = a_i ^ b_i;
      FN_OR:   expected_o = a_i | b_i;
      FN_AND:  expected_o = a_i & b_i;
      FN_SLL:  expected_o = a_i << shamt;
      FN_SRL:  expected_o = a_i >> shamt;
      FN_SRA:  expected_o = a_s >>> shamt;
      FN_SLT:  expected_o = {{(VWIDTH-1){1'b0}}, (a_s < b_s)};
      FN_SLTU: expected_o = {{(VWIDTH-1){1'b0}}, (a_i < b_i)};
      default: expected_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/alu_bist_sequencer.sv
// alu_bist_sequencer: self-test engine for the alu_controller + alu pair.
// Walks a 26-entry op table, drives each entry VECTORS times with LFSR
// operands, and compares aluout against alu_golden_model after SETTLE cycles.
// Ports:
//   clk          in   1       clock, all state on the rising edge
//   rst          in   1       synchronous active-high reset
//   start        in   1       one-cycle run request (acted on in IDLE)
//   instruction  out  IWIDTH  {funct7[5], funct3, opcode} to alu_controller
//   a, b         out  VWIDTH  operands to alu
//   aluout       in   VWIDTH  alu result (combinational from a/b/instruction)
//   busy         out  1       run in progress
//   done         out  1       sticky: sweep finished or first mismatch seen
//   pass         out  1       sticky: sweep clean (valid with done)
//   fail_idx     out  5       op-table index of the first mismatch
//   expected     out  VWIDTH  golden value of the most recent compare
module alu_bist_sequencer
  import alu_bist_pkg::*;
#(
  parameter int          VWIDTH  = 32,
  parameter int          IWIDTH  = 11,
  parameter int          VECTORS = 10,
  parameter int          SETTLE  = 1,
  parameter logic [31:0] SEED    = 32'hACE12023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IWIDTH-1:0] instruction,
  output logic [VWIDTH-1:0] a,
  output logic [VWIDTH-1:0] b,
  input  logic [VWIDTH-1:0] aluout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        fail_idx,
  output logic [VWIDTH-1:0] expected
);

  // An all-zero Galois LFSR never leaves zero, so a zero seed is remapped.
  localparam logic [VWIDTH-1:0] SEED_INIT  = (SEED == 32'd0) ? VWIDTH'(1) : VWIDTH'(SEED);
  localparam logic [VWIDTH-1:0] TAPS       = VWIDTH'(LFSR_TAPS);
  localparam logic [VWIDTH-1:0] SHIFT_MASK = VWIDTH'(31);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [7:0]        VEC_LAST    = 8'(VECTORS - 1);
  localparam logic [4:0]        OP_LAST     = 5'(BIST_OPS - 1);

  function automatic logic [VWIDTH-1:0] lfsr_step(input logic [VWIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

  bist_state_t       state_q, state_d;
  logic [4:0]        op_idx_q, op_idx_d;
  logic [7:0]        vec_cnt_q, vec_cnt_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [VWIDTH-1:0] lfsr_q, lfsr_d;
  logic [IWIDTH-1:0] instr_q, instr_d;
  logic [VWIDTH-1:0] a_q, a_d;
  logic [VWIDTH-1:0] b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [4:0]        fail_idx_q, fail_idx_d;
  logic [VWIDTH-1:0] expected_q, expected_d;

  logic [VWIDTH-1:0] lfsr_s1;
  logic [VWIDTH-1:0] lfsr_s2;
  logic [VWIDTH-1:0] gold;
  logic [10:0]       enc;

  assign lfsr_s1 = lfsr_step(lfsr_q);
  assign lfsr_s2 = lfsr_step(lfsr_s1);

  // Golden model sees the registered operands, i.e. exactly what the alu sees.
  alu_golden_model #(
    .VWIDTH (VWIDTH)
  ) u_golden (
    .op_idx_i   (op_idx_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .expected_o (gold)
  );

  // Op-table encoder: inverse of alu_controller's decode.
  always_comb begin
    enc = 11'b0;
    case (op_idx_q)
      5'd0:    enc = {1'b0, F3_ADD,  OPC_RTYPE};
      5'd1:    enc = {1'b1, F3_ADD,  OPC_RTYPE};
      5'd2:    enc = {1'b0, F3_XOR,  OPC_RTYPE};
      5'd3:    enc = {1'b0, F3_OR,   OPC_RTYPE};
      5'd4:    enc = {1'b0, F3_AND,  OPC_RTYPE};
      5'd5:    enc = {1'b0, F3_SLL,  OPC_RTYPE};
      5'd6:    enc = {1'b0, F3_SR,   OPC_RTYPE};
      5'd7:    enc = {1'b1, F3_SR,   OPC_RTYPE};
      5'd8:    enc = {1'b0, F3_SLT,  OPC_RTYPE};
      5'd9:    enc = {1'b0, F3_SLTU, OPC_RTYPE};
      5'd10:   enc = {1'b0, F3_ADD,  OPC_ITYPE};
      5'd11:   enc = {1'b0, F3_XOR,  OPC_ITYPE};
      5'd12:   enc = {1'b0, F3_OR,   OPC_ITYPE};
      5'd13:   enc = {1'b0, F3_AND,  OPC_ITYPE};
      5'd14:   enc = {1'b0, F3_SLL,  OPC_ITYPE};
      5'd15:   enc = {1'b0, F3_SR,   OPC_ITYPE};
      5'd16:   enc = {1'b1, F3_SR,   OPC_ITYPE};
      5'd17:   enc = {1'b0, F3_SLT,  OPC_ITYPE};
      5'd18:   enc = {1'b0, F3_SLTU, OPC_ITYPE};
      5'd19:   enc = {4'b0, OPC_LOAD};
      5'd20:   enc = {4'b0, OPC_STORE};
      5'd21:   enc = {4'b0, OPC_BRANCH};
      5'd22:   enc = {4'b0, OPC_JAL};
      5'd23:   enc = {4'b0, OPC_JALR};
      5'd24:   enc = {4'b0, OPC_LUI};
      5'd25:   enc = {4'b0, OPC_AUIPC};
      default: enc = 11'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_idx_d   = op_idx_q;
    vec_cnt_d  = vec_cnt_q;
    wait_cnt_d = wait_cnt_q;
    lfsr_d     = lfsr_q;
    instr_d    = instr_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    expected_d = expected_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_idx_d = 5'd0;
          op_idx_d   = 5'd0;
          vec_cnt_d  = 8'd0;
          busy_d     = 1'b1;
          state_d    = ST_DRIVE;
        end
      end

      // Two LFSR steps per vector so A and B are never the same state.
      ST_DRIVE: begin
        instr_d    = enc;
        a_d        = lfsr_q;
        b_d        = op_is_shift(op_idx_q) ? (lfsr_s1 & SHIFT_MASK) : lfsr_s1;
        lfsr_d     = lfsr_s2;
        wait_cnt_d = 4'd0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (wait_cnt_q == SETTLE_LAST) begin
          expected_d = gold;
          if (gold != aluout) begin
            done_d     = 1'b1;
            pass_d     = 1'b0;
            fail_idx_d = op_idx_q;
            busy_d     = 1'b0;
            state_d    = ST_FAIL;
          end else if (vec_cnt_q == VEC_LAST) begin
            if (op_idx_q == OP_LAST) begin
              done_d  = 1'b1;
              pass_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_PASS;
            end else begin
              vec_cnt_d = 8'd0;
              op_idx_d  = op_idx_q + 5'd1;
              state_d   = ST_DRIVE;
            end
          end else begin
            vec_cnt_d = vec_cnt_q + 8'd1;
            state_d   = ST_DRIVE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      // Status and operands stay frozen here so firmware can read them.
      ST_PASS, ST_FAIL: begin
        if (start) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_idx_q   <= 5'd0;
      vec_cnt_q  <= 8'd0;
      wait_cnt_q <= 4'd0;
      lfsr_q     <= SEED_INIT;
      instr_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= 5'd0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      op_idx_q   <= op_idx_d;
      vec_cnt_q  <= vec_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      lfsr_q     <= lfsr_d;
      instr_q    <= instr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      expected_q <= expected_d;
    end
  end

  assign instruction = instr_q;
  assign a           = a_q;
  assign b           = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_idx    = fail_idx_q;
  assign expected    = expected_q;

endmodule
